// File: rtl/reg_bank.sv
// Register bank with per-entry valid flags and a written-entry counter.
// Optional macro REG_BANK_BYPASS_EN forwards write data to out/valid while load=1.
module reg_bank #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [WIDTH-1:0]      out,
  output logic                  valid,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]    regs_q  [DEPTH];
  logic [WIDTH-1:0]    regs_d  [DEPTH];
  logic [DEPTH-1:0]    flags_q;
  logic [DEPTH-1:0]    flags_d;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH:0] count_d;

  // count only moves on a first write, so it saturates at DEPTH by construction
  always_comb begin
    regs_d  = regs_q;
    flags_d = flags_q;
    count_d = count_q;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
      flags_d = '0;
      count_d = '0;
    end else if (load) begin
      regs_d[address] = in;
      if (!flags_q[address]) begin
        flags_d[address] = 1'b1;
        count_d          = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q  <= regs_d;
    flags_q <= flags_d;
    count_q <= count_d;
  end

  always_comb begin
    out   = regs_q[address];
    valid = flags_q[address];
`ifdef REG_BANK_BYPASS_EN
    if (load && !reset) begin
      out   = in;
      valid = 1'b1;
    end
`else
`endif
  end

  assign count = count_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: a default (16x8) and a small (8x4) instance
// compared against an array-based model; honours REG_BANK_BYPASS_EN.
module tb_reg_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in = '0;
  logic        load = 1'b0;
  logic [2:0]  address = '0;
  logic [15:0] out;
  logic        valid;
  logic [3:0]  count;

  logic        reset_s = 1'b0;
  logic [7:0]  in_s = '0;
  logic        load_s = 1'b0;
  logic [1:0]  address_s = '0;
  logic [7:0]  out_s;
  logic        valid_s;
  logic [2:0]  count_s;

  int total = 0;
  int bad = 0;

  logic [15:0] m_mem  [8];
  bit          m_flag [8];
  logic [7:0]  s_mem  [4];
  bit          s_flag [4];

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_bank #(.WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .in(in), .load(load),
    .address(address), .out(out), .valid(valid), .count(count)
  );

  reg_bank #(.WIDTH(8), .ADDR_WIDTH(2)) dut_small (
    .clk(clk), .reset(reset_s), .in(in_s), .load(load_s),
    .address(address_s), .out(out_s), .valid(valid_s), .count(count_s)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += m_flag[i] ? 1 : 0;
    return n;
  endfunction

  function automatic int s_count();
    int n = 0;
    for (int i = 0; i < 4; i++) n += s_flag[i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [15:0] m_out();
    if (BYPASS && load && !reset) return in;
    return m_mem[address];
  endfunction

  function automatic logic m_valid();
    if (BYPASS && load && !reset) return 1'b1;
    return m_flag[address];
  endfunction

  // model of what one rising edge does to the large bank
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[i]  = '0;
        m_flag[i] = 1'b0;
      end
    end else if (load) begin
      m_mem[address]  = in;
      m_flag[address] = 1'b1;
    end
  endtask

  task automatic model_edge_small();
    if (reset_s) begin
      for (int i = 0; i < 4; i++) begin
        s_mem[i]  = '0;
        s_flag[i] = 1'b0;
      end
    end else if (load_s) begin
      s_mem[address_s]  = in_s;
      s_flag[address_s] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    model_edge_small();
    #1;
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    load = 1'b1; address = a; in = d;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset_s = 1'b1;
    tick();
    reset = 1'b0; reset_s = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      total++;
      if (out !== 16'h0000) begin bad++; $display("[TB] FAIL reset_out a=%0d got=%h exp=0000", a, out); end
      total++;
      if (valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid a=%0d got=%b exp=0", a, valid); end
      total++;
      if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    end
  endtask

  task automatic test_write_read();
    write(3'd3, 16'hA5A5);
    address = 3'd3; #1;
    total++;
    if (out !== 16'hA5A5) begin bad++; $display("[TB] FAIL wr_out3 got=%h exp=a5a5", out); end
    total++;
    if (valid !== 1'b1) begin bad++; $display("[TB] FAIL wr_valid3 got=%b exp=1", valid); end
    address = 3'd4; #1;
    total++;
    if (out !== 16'h0000) begin bad++; $display("[TB] FAIL wr_out4 got=%h exp=0000", out); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("[TB] FAIL wr_valid4 got=%b exp=0", valid); end
    total++;
    if (count !== 4'd1) begin bad++; $display("[TB] FAIL wr_count got=%0d exp=1", count); end
  endtask

  task automatic test_rewrite_full();
    write(3'd3, 16'h1234);
    address = 3'd3; #1;
    total++;
    if (out !== 16'h1234) begin bad++; $display("[TB] FAIL rw_out got=%h exp=1234", out); end
    total++;
    if (count !== 4'd1) begin bad++; $display("[TB] FAIL rw_count got=%0d exp=1", count); end
    for (int a = 0; a < 8; a++) write(3'(a), 16'($urandom));
    total++;
    if (count !== 4'd8) begin bad++; $display("[TB] FAIL full_count got=%0d exp=8", count); end
    write(3'($urandom_range(0, 7)), 16'($urandom));
    total++;
    if (count !== 4'd8) begin bad++; $display("[TB] FAIL full_rewrite_count got=%0d exp=8", count); end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a); #1;
      total++;
      if (out !== m_mem[a]) begin bad++; $display("[TB] FAIL full_read a=%0d got=%h exp=%h", a, out, m_mem[a]); end
    end
  endtask

  task automatic test_reset_dominates();
    reset = 1'b1; load = 1'b1; address = 3'd5; in = 16'hFFFF;
    tick();
    reset = 1'b0; load = 1'b0;
    #1;
    total++;
    if (out !== 16'h0000) begin bad++; $display("[TB] FAIL rstdom_out got=%h exp=0000", out); end
    total++;
    if (valid !== 1'b0) begin bad++; $display("[TB] FAIL rstdom_valid got=%b exp=0", valid); end
    total++;
    if (count !== 4'd0) begin bad++; $display("[TB] FAIL rstdom_count got=%0d exp=0", count); end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_now;
    write(3'd2, 16'h5A00);
    load = 1'b1; address = 3'd2; in = 16'h00FF;
    #1;
    exp_now = BYPASS ? 16'h00FF : 16'h5A00;
    total++;
    if (out !== exp_now) begin bad++; $display("[TB] FAIL bypass_pre got=%h exp=%h", out, exp_now); end
    tick();
    load = 1'b0; #1;
    total++;
    if (out !== 16'h00FF) begin bad++; $display("[TB] FAIL bypass_post got=%h exp=00ff", out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      reset   = ($urandom_range(0, 24) == 0);
      load    = $urandom_range(0, 1) == 1;
      address = 3'($urandom);
      in      = 16'($urandom);
      #1;
      total++;
      if (out !== m_out()) begin bad++; $display("[TB] FAIL rand_out i=%0d got=%h exp=%h", i, out, m_out()); end
      total++;
      if (valid !== m_valid()) begin bad++; $display("[TB] FAIL rand_valid i=%0d got=%b exp=%b", i, valid, m_valid()); end
      total++;
      if (count !== 4'(m_count())) begin bad++; $display("[TB] FAIL rand_count i=%0d got=%0d exp=%0d", i, count, m_count()); end
      tick();
    end
    reset = 1'b0; load = 1'b0;
  endtask

  task automatic test_small();
    reset_s = 1'b1; tick(); reset_s = 1'b0;
    total++;
    if (count_s !== 3'd0) begin bad++; $display("[TB] FAIL small_reset_count got=%0d exp=0", count_s); end
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 4; a++) begin
        load_s = 1'b1; address_s = 2'(a); in_s = 8'($urandom);
        tick();
        load_s = 1'b0;
        total++;
        if (count_s !== 3'(s_count())) begin bad++; $display("[TB] FAIL small_count got=%0d exp=%0d", count_s, s_count()); end
      end
    end
    total++;
    if (count_s !== 3'd4) begin bad++; $display("[TB] FAIL small_sat got=%0d exp=4", count_s); end
    for (int a = 0; a < 4; a++) begin
      address_s = 2'(a); #1;
      total++;
      if (out_s !== s_mem[a] || valid_s !== 1'b1) begin
        bad++; $display("[TB] FAIL small_read a=%0d got=%h/%b exp=%h/1", a, out_s, valid_s, s_mem[a]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin m_mem[i] = '0; m_flag[i] = 1'b0; end
    for (int i = 0; i < 4; i++) begin s_mem[i] = '0; s_flag[i] = 1'b0; end
    @(negedge clk);
    test_reset();
    test_write_read();
    test_rewrite_full();
    test_reset_dominates();
    test_bypass();
    test_random();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
